// File: rtl/sram_burst_initiator_if.sv
// Bundle of command, write-stream, read-stream and SRAM-controller signals
// for the burst initiator; master = initiator side, slave = host/controller side.
interface sram_burst_initiator_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8,
   parameter int LEN_W  = 10
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [LEN_W-1:0]  cmd_len;
   logic              wr_valid;
   logic              wr_ready;
   logic [DATA_W-1:0] wr_data;
   logic              rd_valid;
   logic              rd_ready;
   logic [DATA_W-1:0] rd_data;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic              mem_re;
   logic [DATA_W-1:0] mem_rdata;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] chksum;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_len,
      input  wr_valid, wr_data, rd_ready, mem_rdata,
      output cmd_ready, wr_ready, rd_valid, rd_data,
      output mem_addr, mem_wdata, mem_we, mem_re,
      output busy, done, chksum
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_len,
      output wr_valid, wr_data, rd_ready, mem_rdata,
      input  cmd_ready, wr_ready, rd_valid, rd_data,
      input  mem_addr, mem_wdata, mem_we, mem_re,
      input  busy, done, chksum
   );
endinterface

// File: rtl/sram_burst_initiator.sv
// Burst command to single-word SRAM controller accesses, with a credit-limited read FIFO.
// Optional XOR checksum of burst beats is enabled by defining SRAM_BURST_CHKSUM_EN.
module sram_burst_initiator #(
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 8,
   parameter int LEN_W    = 10,
   parameter int RD_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   sram_burst_initiator_if.master bus
);
   localparam int PTR_W = $clog2(RD_DEPTH);
   localparam int CRD_W = PTR_W + 2;

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              mem_we_q;
   logic              mem_re_q;
   logic              re_p1_q;
   logic              done_q, done_d;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  beat_q;
   logic [LEN_W-1:0]  iss_q;
   logic              iss_done_q;
   logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
   logic [DATA_W-1:0] fifo_mem [RD_DEPTH];

   logic              cmd_hs, wr_hs, rd_pop, rd_valid, issue;
   logic [PTR_W:0]    fifo_count;
   logic [CRD_W-1:0]  credit_used;

   assign cmd_hs     = bus.cmd_valid && (state_q == S_IDLE);
   assign wr_hs      = bus.wr_valid && (state_q == S_WRITE);
   assign rd_valid   = (wr_ptr_q != rd_ptr_q);
   assign rd_pop     = rd_valid && bus.rd_ready;
   assign fifo_count = wr_ptr_q - rd_ptr_q;
   // FIFO slots already promised: stored words plus reads still in the controller pipe
   assign credit_used = CRD_W'(fifo_count) + CRD_W'(mem_re_q) + CRD_W'(re_p1_q);

   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      done_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_hs) begin
               state_d = bus.cmd_write ? S_WRITE : S_READ;
            end
         end
         S_WRITE: begin
            if (wr_hs && (beat_q == len_q)) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         S_READ: begin
            issue = !iss_done_q && (credit_used < CRD_W'(RD_DEPTH));
            if (rd_pop && (beat_q == len_q)) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
         re_p1_q     <= 1'b0;
         done_q      <= 1'b0;
         len_q       <= '0;
         beat_q      <= '0;
         iss_q       <= '0;
         iss_done_q  <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
      end else begin
         state_q  <= state_d;
         done_q   <= done_d;
         mem_we_q <= wr_hs;
         mem_re_q <= issue;
         re_p1_q  <= mem_re_q;
         if (cmd_hs) begin
            addr_q     <= bus.cmd_addr;
            len_q      <= bus.cmd_len;
            beat_q     <= '0;
            iss_q      <= '0;
            iss_done_q <= 1'b0;
         end
         if (wr_hs) begin
            mem_addr_q  <= addr_q;
            mem_wdata_q <= bus.wr_data;
            addr_q      <= addr_q + 1'b1;
            beat_q      <= beat_q + 1'b1;
         end
         if (issue) begin
            mem_addr_q <= addr_q;
            addr_q     <= addr_q + 1'b1;
            iss_q      <= iss_q + 1'b1;
            if (iss_q == len_q) begin
               iss_done_q <= 1'b1;
            end
         end
         if (rd_pop) begin
            beat_q   <= beat_q + 1'b1;
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         // controller data_out is valid the cycle after mem_re was seen
         if (re_p1_q) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (re_p1_q) begin
         fifo_mem[wr_ptr_q[PTR_W-1:0]] <= bus.mem_rdata;
      end
   end

`ifdef SRAM_BURST_CHKSUM_EN
   logic [DATA_W-1:0] chksum_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         chksum_q <= '0;
      end else if (cmd_hs) begin
         chksum_q <= '0;
      end else if (wr_hs) begin
         chksum_q <= chksum_q ^ bus.wr_data;
      end else if (rd_pop) begin
         chksum_q <= chksum_q ^ bus.rd_data;
      end
   end

   assign bus.chksum = chksum_q;
`else
   assign bus.chksum = '0;
`endif

   assign bus.cmd_ready = (state_q == S_IDLE);
   assign bus.wr_ready  = (state_q == S_WRITE);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = done_q;
   assign bus.rd_valid  = rd_valid;
   assign bus.rd_data   = rd_valid ? fifo_mem[rd_ptr_q[PTR_W-1:0]] : '0;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_re    = mem_re_q;
endmodule

// File: tb/tb_sram_burst_initiator.sv
// Self-checking bench for sram_burst_initiator: table of bursts driven against an SRAM model,
// scoreboard queues for write beats and read returns, plus hand-written abort/stall sequences.
module tb_sram_burst_initiator;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   sram_burst_initiator_if bus ();

   sram_burst_initiator dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // SRAM controller model: one-cycle read latency on data_out
   logic [7:0] sram [1024];
   always @(posedge clk) begin
      if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_re) bus.mem_rdata <= sram[bus.mem_addr];
   end

   typedef struct {
      bit         wr;
      logic [9:0] addr;
      logic [9:0] len;
      int         stall;     // 0 none, 1 alternate, 2 random
      int         rd_rand;
      int         hold0;     // cycles of rd_ready=0 at burst start
      int         dmode;     // 0 nibble pattern, 1 one-hot
      int         linger;
      int         exp_beats;
      logic [9:0] exp_end;
   } vec_t;

   typedef struct {
      logic [9:0] addr;
      logic [7:0] data;
   } wexp_t;

   vec_t       vecs [12];
   wexp_t      wq [$];
   logic [7:0] rq [$];
   logic [7:0] shadow [1024];
   logic [7:0] model_chk;
   logic [9:0] wr_cursor;
   logic       exp_we_next;
   int n_cmp, n_fail;
   int we_cnt, re_cnt, pop_cnt, done_cnt, cyc, first_re, first_rv, wr_sent;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] gen(input int dmode, input int b);
      if (dmode == 1) return 8'(1 << b);
      return {4'(10 + b), 4'(1 + b)};
   endfunction

   // Note handshakes presented for the coming edge, then check outputs at the next negedge.
   task automatic step();
      logic [7:0] e;
      exp_we_next = !rst && bus.wr_valid && bus.wr_ready;
      if (!rst && bus.wr_valid && bus.wr_ready) begin
         wq.push_back('{wr_cursor, bus.wr_data});
         shadow[wr_cursor] = bus.wr_data;
         model_chk ^= bus.wr_data;
         wr_cursor++;
         wr_sent++;
      end
      if (!rst && bus.rd_valid && bus.rd_ready) begin
         pop_cnt++;
         chk("pop_expected", 32'(rq.size() > 0), 1);
         if (rq.size() > 0) begin
            e = rq.pop_front();
            chk("rd_data", bus.rd_data, e);
            model_chk ^= e;
         end
      end
      @(negedge clk);
      cyc++;
      chk("mem_we_timing", bus.mem_we, exp_we_next);
      chk("we_re_exclusive", bus.mem_we & bus.mem_re, 0);
      if (bus.mem_we) begin
         we_cnt++;
         chk("write_expected", 32'(wq.size() > 0), 1);
         if (wq.size() > 0) begin
            wexp_t w;
            w = wq.pop_front();
            chk("wr_addr", bus.mem_addr, w.addr);
            chk("wr_data", bus.mem_wdata, w.data);
         end
      end
      if (bus.mem_re) begin
         re_cnt++;
         if (first_re < 0) first_re = cyc;
      end
      if (bus.rd_valid && first_rv < 0) first_rv = cyc;
      if (bus.done) done_cnt++;
   endtask

   task automatic start_cmd(input bit wr, input logic [9:0] addr, input logic [9:0] len, input bit rdy);
      int g = 0;
      while (!bus.cmd_ready && g < 200) begin
         step();
         g++;
      end
      chk("cmd_ready", bus.cmd_ready, 1);
      we_cnt = 0; re_cnt = 0; pop_cnt = 0; done_cnt = 0;
      first_re = -1; first_rv = -1; wr_sent = 0; model_chk = 8'h00;
      wr_cursor = addr;
      if (!wr) begin
         for (int i = 0; i <= int'(len); i++) rq.push_back(shadow[10'(addr + 10'(i))]);
      end
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = addr;
      bus.cmd_len   = len;
      bus.wr_valid  = 1'b0;
      bus.rd_ready  = rdy;
      step();
      bus.cmd_valid = 1'b0;
      chk("busy_after_cmd", bus.busy, 1);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int budget;
      logic [7:0] exp_chk;
      budget = (int'(v.len) + 1) * 4 + 60;
      start_cmd(v.wr, v.addr, v.len, v.hold0 == 0);
      for (int t = 0; t < budget && done_cnt == 0; t++) begin
         if (v.hold0 > 0 && t == v.hold0) begin
            chk("credit_stall_re", re_cnt, 4);
            chk("credit_stall_valid", bus.rd_valid, 1);
         end
         if (v.wr) begin
            if (wr_sent <= int'(v.len) && (v.stall == 0 || (v.stall == 1 && t % 2 == 0) ||
                (v.stall == 2 && $urandom_range(0, 1) == 1))) begin
               bus.wr_valid = 1'b1;
               bus.wr_data  = gen(v.dmode, wr_sent);
            end else begin
               bus.wr_valid = 1'b0;
            end
         end else begin
            bus.rd_ready = (t < v.hold0) ? 1'b0 : (v.rd_rand != 0 ? 1'($urandom_range(0, 1)) : 1'b1);
         end
         step();
      end
      bus.wr_valid = 1'b0;
      chk("done_seen", done_cnt, 1);
      if (v.wr) begin
         chk("done_with_last_we", bus.mem_we, 1);
         chk("write_beats", we_cnt, v.exp_beats);
      end else begin
         chk("idle_at_done", bus.busy, 0);
         chk("read_beats", pop_cnt, v.exp_beats);
         chk("read_issues", re_cnt, v.exp_beats);
         chk("rd_latency", first_rv - first_re, 2);
      end
      chk("cmd_ready_at_done", bus.cmd_ready, 1);
      chk("mem_addr_end", bus.mem_addr, v.exp_end);
`ifdef SRAM_BURST_CHKSUM_EN
      exp_chk = model_chk;
`else
      exp_chk = 8'h00;
`endif
      chk("chksum", bus.chksum, exp_chk);
      for (int i = 0; i < v.linger; i++) step();
      chk("done_one_pulse", done_cnt, 1);
      chk("queues_drained", wq.size() + rq.size(), 0);
      bus.rd_ready = 1'b1;
      $display("burst %0d: %s addr=%03h len=%0d beats=%0d chksum=%02h", idx, v.wr ? "WR" : "RD",
               v.addr, v.len, v.wr ? we_cnt : pop_cnt, bus.chksum);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //          wr    addr     len     stl rnd hold dm lg beats end
      vecs[0]  = '{1'b1, 10'h010, 10'd3,   0, 0, 0,  0, 3, 4,    10'h013};
      vecs[1]  = '{1'b0, 10'h010, 10'd3,   0, 0, 0,  0, 3, 4,    10'h013};
      vecs[2]  = '{1'b1, 10'h3FE, 10'd3,   1, 0, 0,  0, 3, 4,    10'h001};
      vecs[3]  = '{1'b0, 10'h3FE, 10'd3,   0, 1, 0,  0, 3, 4,    10'h001};
      vecs[4]  = '{1'b1, 10'h050, 10'd3,   0, 0, 0,  1, 3, 4,    10'h053};
      vecs[5]  = '{1'b1, 10'h200, 10'd15,  2, 0, 0,  0, 3, 16,   10'h20F};
      vecs[6]  = '{1'b0, 10'h200, 10'd7,   0, 0, 20, 0, 3, 8,    10'h207};
      vecs[7]  = '{1'b0, 10'h200, 10'd15,  0, 1, 0,  0, 3, 16,   10'h20F};
      vecs[8]  = '{1'b1, 10'h060, 10'd0,   0, 0, 0,  0, 0, 1,    10'h060};
      vecs[9]  = '{1'b0, 10'h060, 10'd0,   0, 0, 0,  0, 3, 1,    10'h060};
      vecs[10] = '{1'b1, 10'h000, 10'h3FF, 0, 0, 0,  0, 3, 1024, 10'h3FF};
      vecs[11] = '{1'b0, 10'h000, 10'h3FF, 0, 1, 0,  0, 3, 1024, 10'h3FF};

      n_cmp = 0; n_fail = 0; cyc = 0; exp_we_next = 1'b0;
      we_cnt = 0; re_cnt = 0; pop_cnt = 0; done_cnt = 0; first_re = -1; first_rv = -1;
      wr_sent = 0; wr_cursor = '0; model_chk = 8'h00;
      rst = 1'b1;
      bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
      bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;

      repeat (3) step();
      chk("rst_cmd_ready", bus.cmd_ready, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_wr_ready", bus.wr_ready, 0);
      chk("rst_rd_valid", bus.rd_valid, 0);
      chk("rst_rd_data", bus.rd_data, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_re", bus.mem_re, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_chksum", bus.chksum, 0);
      rst = 1'b0;
      step();

      for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

      // Abort a read of 8 beats after its second beat is consumed
      start_cmd(1'b0, 10'h200, 10'd7, 1'b1);
      for (int g = 0; g < 100 && pop_cnt < 2; g++) step();
      chk("abort_reached_beat2", pop_cnt, 2);
      rst = 1'b1;
      bus.rd_ready = 1'b0;
      step();
      chk("abort_busy", bus.busy, 0);
      chk("abort_rd_valid", bus.rd_valid, 0);
      chk("abort_mem_re", bus.mem_re, 0);
      chk("abort_mem_we", bus.mem_we, 0);
      chk("abort_done", bus.done, 0);
      chk("abort_cmd_ready", bus.cmd_ready, 1);
      rst = 1'b0;
      rq.delete();
      done_cnt = 0;
      re_cnt = 0;
      bus.rd_ready = 1'b1;
      repeat (6) step();
      chk("abort_no_done", done_cnt, 0);
      chk("abort_no_reissue", re_cnt, 0);
      chk("abort_fifo_empty", bus.rd_valid, 0);
      $display("burst abort: RD addr=200 len=7 reset after 2 beats");

      run_vec(vecs[0], 12);
      run_vec(vecs[1], 13);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
